// File: rtl/hdmi_packet_pkg.sv
// Shared constants, state encoding and helpers for the HDMI data-island scheduler.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI_IF       = 8'h82;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int CNT_W        = 5;

    // Encoding doubles as the island_phase output value.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_LEAD_GUARD  = 3'd2,
        ST_PACKET      = 3'd3,
        ST_TRAIL_GUARD = 3'd4
    } state_t;

    function automatic logic [4:0] clamp_slots(input logic [4:0] slots, input int max_slots);
        return (int'(slots) > max_slots) ? 5'(max_slots) : slots;
    endfunction

endpackage

// File: rtl/hdmi_packet_priority_pick.sv
// Combinational fixed-priority packet source selection; InfoFrame sources exist
// only when HDMI_PACKET_SCHED_INFOFRAME_EN is defined.
module hdmi_packet_priority_pick
    import hdmi_packet_pkg::*;
(
    input  logic       acr_req,
    input  logic       audio_req,
`ifdef HDMI_PACKET_SCHED_INFOFRAME_EN
    input  logic       avi_pend,
    input  logic       aif_pend,
    output logic       avi_grant,
    output logic       aif_grant,
`endif
    output logic [7:0] packet_type,
    output logic       acr_grant,
    output logic       audio_grant
);

    always_comb begin
        packet_type = PKT_NULL;
        acr_grant   = 1'b0;
        audio_grant = 1'b0;
`ifdef HDMI_PACKET_SCHED_INFOFRAME_EN
        avi_grant   = 1'b0;
        aif_grant   = 1'b0;
`endif
        if (acr_req) begin
            packet_type = PKT_ACR;
            acr_grant   = 1'b1;
        end else if (audio_req) begin
            packet_type = PKT_AUDIO_SAMPLE;
            audio_grant = 1'b1;
        end
`ifdef HDMI_PACKET_SCHED_INFOFRAME_EN
        else if (avi_pend) begin
            packet_type = PKT_AVI_IF;
            avi_grant   = 1'b1;
        end else if (aif_pend) begin
            packet_type = PKT_AUDIO_IF;
            aif_grant   = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island scheduler: preamble, guard bands and prioritised packet slots.
// Optional InfoFrame scheduling enabled by defining HDMI_PACKET_SCHED_INFOFRAME_EN.
module hdmi_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int MAX_SLOTS = 18,
    parameter int MISS_W    = 8
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              island_start,
    input  logic [4:0]        island_slots,
    input  logic              frame_start,
    input  logic              acr_req,
    input  logic              audio_req,
    output logic [2:0]        island_phase,
    output logic              packet_start,
    output logic [7:0]        packet_type,
    output logic              acr_ack,
    output logic              audio_ack,
    output logic [MISS_W-1:0] audio_miss
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [4:0]        slot_reg, slot_next;
    logic [4:0]        slots_reg, slots_next;
    logic [7:0]        packet_type_reg, packet_type_next;
    logic              packet_start_reg, packet_start_next;
    logic              acr_ack_reg, acr_ack_next;
    logic              audio_ack_reg, audio_ack_next;
    logic [MISS_W-1:0] audio_miss_reg, audio_miss_next;
    logic              decide;

    logic [7:0]        pick_type;
    logic              acr_grant, audio_grant;

`ifdef HDMI_PACKET_SCHED_INFOFRAME_EN
    logic avi_pend_reg, avi_pend_next;
    logic aif_pend_reg, aif_pend_next;
    logic avi_grant, aif_grant;

    hdmi_packet_priority_pick u_pick (
        .acr_req     (acr_req),
        .audio_req   (audio_req),
        .avi_pend    (avi_pend_reg),
        .aif_pend    (aif_pend_reg),
        .avi_grant   (avi_grant),
        .aif_grant   (aif_grant),
        .packet_type (pick_type),
        .acr_grant   (acr_grant),
        .audio_grant (audio_grant)
    );

    // A new frame re-arms the InfoFrames even if one is granted in the same cycle.
    always_comb begin
        avi_pend_next = frame_start | (avi_pend_reg & ~(decide & avi_grant));
        aif_pend_next = frame_start | (aif_pend_reg & ~(decide & aif_grant));
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            avi_pend_reg <= 1'b1;
            aif_pend_reg <= 1'b1;
        end else begin
            avi_pend_reg <= avi_pend_next;
            aif_pend_reg <= aif_pend_next;
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;

    hdmi_packet_priority_pick u_pick (
        .acr_req     (acr_req),
        .audio_req   (audio_req),
        .packet_type (pick_type),
        .acr_grant   (acr_grant),
        .audio_grant (audio_grant)
    );
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            slot_reg         <= '0;
            slots_reg        <= '0;
            packet_type_reg  <= PKT_NULL;
            packet_start_reg <= 1'b0;
            acr_ack_reg      <= 1'b0;
            audio_ack_reg    <= 1'b0;
            audio_miss_reg   <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            slot_reg         <= slot_next;
            slots_reg        <= slots_next;
            packet_type_reg  <= packet_type_next;
            packet_start_reg <= packet_start_next;
            acr_ack_reg      <= acr_ack_next;
            audio_ack_reg    <= audio_ack_next;
            audio_miss_reg   <= audio_miss_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg + 1'b1;
        slot_next         = slot_reg;
        slots_next        = slots_reg;
        packet_type_next  = packet_type_reg;
        packet_start_next = 1'b0;
        acr_ack_next      = 1'b0;
        audio_ack_next    = 1'b0;
        audio_miss_next   = audio_miss_reg;
        decide            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next         = '0;
                packet_type_next = PKT_NULL;
                if (island_start && (island_slots != 5'd0)) begin
                    state_next = ST_PREAMBLE;
                    slots_next = clamp_slots(island_slots, MAX_SLOTS);
                end
            end
            ST_PREAMBLE: begin
                if (cnt_reg == CNT_W'(PREAMBLE_LEN - 1)) begin
                    state_next = ST_LEAD_GUARD;
                    cnt_next   = '0;
                end
            end
            ST_LEAD_GUARD: begin
                if (cnt_reg == CNT_W'(GUARD_LEN - 1)) begin
                    state_next = ST_PACKET;
                    cnt_next   = '0;
                    slot_next  = '0;
                    decide     = 1'b1;
                end
            end
            ST_PACKET: begin
                if (cnt_reg == CNT_W'(PACKET_LEN - 1)) begin
                    cnt_next = '0;
                    if (slot_reg == slots_reg - 5'd1) begin
                        state_next       = ST_TRAIL_GUARD;
                        packet_type_next = PKT_NULL;
                    end else begin
                        slot_next = slot_reg + 5'd1;
                        decide    = 1'b1;
                    end
                end
            end
            ST_TRAIL_GUARD: begin
                // First trail-guard cycle: audio still waiting means it missed this island.
                if ((cnt_reg == '0) && audio_req && (audio_miss_reg != '1))
                    audio_miss_next = audio_miss_reg + 1'b1;
                if (cnt_reg == CNT_W'(GUARD_LEN - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (decide) begin
            packet_start_next = 1'b1;
            packet_type_next  = pick_type;
            acr_ack_next      = acr_grant;
            audio_ack_next    = audio_grant;
        end
    end

    assign island_phase = state_reg;
    assign packet_start = packet_start_reg;
    assign packet_type  = packet_type_reg;
    assign acr_ack      = acr_ack_reg;
    assign audio_ack    = audio_ack_reg;
    assign audio_miss   = audio_miss_reg;

endmodule
